// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle main controller and its
// opcode classifier.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        ALUWB  = 4'd3,
        IEXEC  = 4'd4,
        IWB    = 4'd5,
        MEMADR = 4'd6,
        MEMRD  = 4'd7,
        MEMWB  = 4'd8,
        MEMWR  = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    localparam logic [4:0] OP_ADDI = 5'b11000;
    localparam logic [4:0] OP_SUBI = 5'b11001;
    localparam logic [4:0] OP_LW   = 5'b11010;
    localparam logic [4:0] OP_SW   = 5'b11011;
    localparam logic [4:0] OP_BEQ  = 5'b11100;
    localparam logic [4:0] OP_BNE  = 5'b11101;
    localparam logic [4:0] OP_J    = 5'b00000;
    localparam logic [4:0] OP_JAL  = 5'b00111;

    // Bit positions inside the one-hot class vector.
    localparam int CLS_R    = 0;
    localparam int CLS_ADDI = 1;
    localparam int CLS_SUBI = 2;
    localparam int CLS_LW   = 3;
    localparam int CLS_SW   = 4;
    localparam int CLS_BEQ  = 5;
    localparam int CLS_BNE  = 6;
    localparam int CLS_J    = 7;
    localparam int CLS_JAL  = 8;
    localparam int CLS_N    = 9;

    typedef logic [CLS_N-1:0] cls_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_TRAP   = 2'b11;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       pcwrite_eq;
        logic       pcwrite_ne;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       link;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_op_class.sv
// Combinational opcode classifier: top five opcode bits to a one-hot class
// vector plus an illegal flag.
module mc_op_class
    import mc_ctrl_pkg::*;
(
    input  logic [4:0] op5,
    output cls_t       cls,
    output logic       illegal
);

    always_comb begin
        cls = '0;
        if (op5[4:3] == 2'b01 || op5[4:3] == 2'b10) begin
            cls[CLS_R] = 1'b1;
        end else begin
            case (op5)
                OP_ADDI: cls[CLS_ADDI] = 1'b1;
                OP_SUBI: cls[CLS_SUBI] = 1'b1;
                OP_LW:   cls[CLS_LW]   = 1'b1;
                OP_SW:   cls[CLS_SW]   = 1'b1;
                OP_BEQ:  cls[CLS_BEQ]  = 1'b1;
                OP_BNE:  cls[CLS_BNE]  = 1'b1;
                OP_J:    cls[CLS_J]    = 1'b1;
                OP_JAL:  cls[CLS_JAL]  = 1'b1;
                default: cls = '0;
            endcase
        end
        illegal = ~|cls;
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle main controller: sequences each instruction through its states,
// stalls on mem_ready, traps illegal opcodes and counts retired instructions.
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ready,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             pcwrite_eq,
    output logic             pcwrite_ne,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsrc,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             link,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Sub-class selectors captured in DECODE so later states ignore op.
    logic             sw_q, sw_d;
    logic             bne_q, bne_d;
    logic             jal_q, jal_d;

    cls_t  cls;
    logic  cls_illegal;
    logic  retire;
    ctrl_t ctrl;

    mc_op_class u_op_class (
        .op5     (op[OP_W-1 -: 5]),
        .cls     (cls),
        .illegal (cls_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            sw_q    <= 1'b0;
            bne_q   <= 1'b0;
            jal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            bne_q   <= bne_d;
            jal_q   <= jal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sw_d    = sw_q;
        bne_d   = bne_q;
        jal_d   = jal_q;
        retire  = 1'b0;
        ctrl    = '0;

        case (state_q)
            FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_ONE;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
                sw_d  = cls[CLS_SW];
                bne_d = cls[CLS_BNE];
                jal_d = cls[CLS_JAL];
                if (cls_illegal)                          state_d = TRAP;
                else if (cls[CLS_R])                      state_d = EXEC;
                else if (cls[CLS_ADDI] || cls[CLS_SUBI])  state_d = IEXEC;
                else if (cls[CLS_LW] || cls[CLS_SW])      state_d = MEMADR;
                else if (cls[CLS_BEQ] || cls[CLS_BNE])    state_d = BRANCH;
                else                                      state_d = JUMP;
            end
            EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REGB;
                ctrl.aluop   = ALUOP_RTYPE;
                state_d      = ALUWB;
            end
            ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                retire        = 1'b1;
                state_d       = FETCH;
            end
            IEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = cls[CLS_SUBI] ? ALUOP_SUB : ALUOP_ADD;
                state_d      = IWB;
            end
            IWB: begin
                ctrl.regwrite = 1'b1;
                retire        = 1'b1;
                state_d       = FETCH;
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
                state_d      = sw_q ? MEMWR : MEMRD;
            end
            MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                retire        = 1'b1;
                state_d       = FETCH;
            end
            MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = SRCB_REGB;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.pcwrite_eq = ~bne_q;
                ctrl.pcwrite_ne = bne_q;
                retire          = 1'b1;
                state_d         = FETCH;
            end
            JUMP: begin
                ctrl.pcsrc    = PCSRC_JUMP;
                ctrl.pcwrite  = 1'b1;
                ctrl.link     = jal_q;
                ctrl.regwrite = jal_q;
                retire        = 1'b1;
                state_d       = FETCH;
            end
            TRAP: begin
                ctrl.illegal = 1'b1;
                ctrl.pcsrc   = PCSRC_TRAP;
                ctrl.pcwrite = 1'b1;
                state_d      = FETCH;
            end
            default: state_d = FETCH;
        endcase

        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // Outputs are gated by reset_n so nothing strobes while reset is held.
    assign iord        = reset_n & ctrl.iord;
    assign memread     = reset_n & ctrl.memread;
    assign memwrite    = reset_n & ctrl.memwrite;
    assign irwrite     = reset_n & ctrl.irwrite;
    assign pcwrite     = reset_n & ctrl.pcwrite;
    assign pcwrite_eq  = reset_n & ctrl.pcwrite_eq;
    assign pcwrite_ne  = reset_n & ctrl.pcwrite_ne;
    assign alusrca     = reset_n & ctrl.alusrca;
    assign alusrcb     = reset_n ? ctrl.alusrcb : 2'b00;
    assign aluop       = reset_n ? ctrl.aluop   : 2'b00;
    assign pcsrc       = reset_n ? ctrl.pcsrc   : 2'b00;
    assign regdst      = reset_n & ctrl.regdst;
    assign memtoreg    = reset_n & ctrl.memtoreg;
    assign regwrite    = reset_n & ctrl.regwrite;
    assign link        = reset_n & ctrl.link;
    assign illegal     = reset_n & ctrl.illegal;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed, table-driven bench for mc_main_ctrl (CNT_W=4 to reach the wrap).
module tb_mc_main_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic [4:0]       op;
    logic             mem_ready;
    logic             iord, memread, memwrite, irwrite, pcwrite;
    logic             pcwrite_eq, pcwrite_ne, alusrca;
    logic [1:0]       alusrcb, aluop, pcsrc;
    logic             regdst, memtoreg, regwrite, link, illegal;
    logic [CNT_W-1:0] instr_count;
    logic [18:0]      outs;

    mc_main_ctrl #(.OP_W(5), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .mem_ready   (mem_ready),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .pcwrite     (pcwrite),
        .pcwrite_eq  (pcwrite_eq),
        .pcwrite_ne  (pcwrite_ne),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .aluop       (aluop),
        .pcsrc       (pcsrc),
        .regdst      (regdst),
        .memtoreg    (memtoreg),
        .regwrite    (regwrite),
        .link        (link),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    assign outs = {iord, memread, memwrite, irwrite, pcwrite, pcwrite_eq,
                   pcwrite_ne, alusrca, alusrcb, aluop, pcsrc,
                   regdst, memtoreg, regwrite, link, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {iord,memread,memwrite,irwrite,pcwrite,eq,ne,alusrca}, alusrcb, aluop,
    // pcsrc, {regdst,memtoreg,regwrite,link,illegal}
    localparam logic [18:0] E_ZERO = 19'd0;
    localparam logic [18:0] E_F0   = {8'b01000000, 2'b01, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_F1   = {8'b01011000, 2'b01, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_DEC  = {8'b00000000, 2'b10, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_EXEC = {8'b00000001, 2'b00, 2'b10, 2'b00, 5'b00000};
    localparam logic [18:0] E_AWB  = {8'b00000000, 2'b00, 2'b00, 2'b00, 5'b10100};
    localparam logic [18:0] E_IADD = {8'b00000001, 2'b10, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_ISUB = {8'b00000001, 2'b10, 2'b11, 2'b00, 5'b00000};
    localparam logic [18:0] E_IWB  = {8'b00000000, 2'b00, 2'b00, 2'b00, 5'b00100};
    localparam logic [18:0] E_MADR = {8'b00000001, 2'b10, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_MRD  = {8'b11000000, 2'b00, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_MWB  = {8'b00000000, 2'b00, 2'b00, 2'b00, 5'b01100};
    localparam logic [18:0] E_MWR  = {8'b10100000, 2'b00, 2'b00, 2'b00, 5'b00000};
    localparam logic [18:0] E_BEQ  = {8'b00000101, 2'b00, 2'b11, 2'b01, 5'b00000};
    localparam logic [18:0] E_BNE  = {8'b00000011, 2'b00, 2'b11, 2'b01, 5'b00000};
    localparam logic [18:0] E_J    = {8'b00001000, 2'b00, 2'b00, 2'b10, 5'b00000};
    localparam logic [18:0] E_JAL  = {8'b00001000, 2'b00, 2'b00, 2'b10, 5'b00110};
    localparam logic [18:0] E_TRAP = {8'b00001000, 2'b00, 2'b00, 2'b11, 5'b00001};

    typedef struct {
        logic [4:0]       op;
        logic             rdy;
        logic [18:0]      exp_o;
        logic [CNT_W-1:0] exp_c;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic add(input logic [4:0] o, input logic r,
                       input logic [18:0] e, input logic [CNT_W-1:0] c);
        vec_t v;
        v.op = o; v.rdy = r; v.exp_o = e; v.exp_c = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One cycle: drive inputs just after the edge, check mid-cycle.
    task automatic step(input string name, input logic [4:0] o, input logic r,
                        input logic [18:0] e, input logic [CNT_W-1:0] c);
        op = o;
        mem_ready = r;
        @(negedge clk);
        $display("%s op=%b rdy=%b outs=%h cnt=%0d", name, o, r, outs, instr_count);
        chk({name, ".outs"}, 32'(outs), 32'(e));
        chk({name, ".cnt"}, 32'(instr_count), 32'(c));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        op        = 5'b0;
        mem_ready = 1'b1;
        #3;
        chk("reset.outs", 32'(outs), 32'(E_ZERO));
        chk("reset.cnt", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // R-type; op changes outside DECODE must be ignored
        add(5'b01010, 1, E_F1, 0);  add(5'b01010, 1, E_DEC, 0);
        add(5'b01010, 1, E_EXEC, 0); add(5'b11110, 1, E_AWB, 0);
        // LW with two MEMRD stall cycles
        add(5'b11010, 1, E_F1, 1);  add(5'b11010, 1, E_DEC, 1);
        add(5'b11111, 1, E_MADR, 1); add(5'b11111, 0, E_MRD, 1);
        add(5'b11111, 0, E_MRD, 1); add(5'b11011, 1, E_MRD, 1);
        add(5'b11010, 1, E_MWB, 1);
        // BNE
        add(5'b11101, 1, E_F1, 2);  add(5'b11101, 1, E_DEC, 2);
        add(5'b11100, 1, E_BNE, 2);
        // JAL
        add(5'b00111, 1, E_F1, 3);  add(5'b00111, 1, E_DEC, 3);
        add(5'b00000, 1, E_JAL, 3);
        // Two illegal opcodes, not counted
        add(5'b11110, 1, E_F1, 4);  add(5'b11110, 1, E_DEC, 4);
        add(5'b11110, 1, E_TRAP, 4);
        add(5'b00101, 1, E_F1, 4);  add(5'b00101, 1, E_DEC, 4);
        add(5'b00101, 1, E_TRAP, 4);
        // ADDI, SUBI
        add(5'b11000, 1, E_F1, 4);  add(5'b11000, 1, E_DEC, 4);
        add(5'b11000, 1, E_IADD, 4); add(5'b11000, 1, E_IWB, 4);
        add(5'b11001, 1, E_F1, 5);  add(5'b11001, 1, E_DEC, 5);
        add(5'b11001, 1, E_ISUB, 5); add(5'b11001, 1, E_IWB, 5);
        // BEQ, J
        add(5'b11100, 1, E_F1, 6);  add(5'b11100, 1, E_DEC, 6);
        add(5'b11100, 1, E_BEQ, 6);
        add(5'b00000, 1, E_F1, 7);  add(5'b00000, 1, E_DEC, 7);
        add(5'b00000, 1, E_J, 7);
        // SW with a fetch stall and one MEMWR stall
        add(5'b11011, 0, E_F0, 8);  add(5'b11011, 1, E_F1, 8);
        add(5'b11011, 1, E_DEC, 8); add(5'b11011, 1, E_MADR, 8);
        add(5'b11011, 0, E_MWR, 8); add(5'b11011, 1, E_MWR, 8);
        // R-type with top bits 10
        add(5'b10001, 1, E_F1, 9);  add(5'b10001, 1, E_DEC, 9);
        add(5'b10001, 1, E_EXEC, 9); add(5'b10001, 1, E_AWB, 9);
        add(5'b11011, 1, E_F1, 10);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].op, vecs[i].rdy,
                 vecs[i].exp_o, vecs[i].exp_c);
        end

        // Reset dropped during a MEMWR stall
        step("sw.dec", 5'b11011, 1, E_DEC, 10);
        step("sw.madr", 5'b11011, 1, E_MADR, 10);
        step("sw.stall", 5'b11011, 0, E_MWR, 10);
        #2;
        reset_n = 1'b0;
        #1;
        $display("midrst outs=%h cnt=%0d", outs, instr_count);
        chk("midrst.outs", 32'(outs), 32'(E_ZERO));
        chk("midrst.cnt", 32'(instr_count), 32'd0);
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.hold_outs", 32'(outs), 32'(E_ZERO));
        reset_n = 1'b1;
        step("post_rst.f0", 5'b11011, 0, E_F0, 0);
        step("post_rst.f1", 5'b11011, 1, E_F1, 0);

        // Counter wrap: 17 SW instructions from reset
        do_reset();
        op = 5'b11011;
        mem_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            repeat (4) @(posedge clk);
            #1;
            $display("wrap sw%0d cnt=%0d", i, instr_count);
            chk($sformatf("wrap.sw%0d", i), 32'(instr_count), 32'(i % 16));
        end
        chk("wrap.fetch", 32'(outs), 32'(E_F1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mc_main_ctrl.md
# mc_main_ctrl

Multicycle main controller for the 5-bit-opcode core: a parametrised, sequential successor to the single-cycle main decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states, stalls on a memory ready handshake, and traps illegal opcodes. It also keeps a retired-instruction counter. It sits in the controller beside the ALU decoder and drives the multicycle datapath muxes and enables.

## Interface
- OP_W, 5, opcode width (≥5); decode uses op[OP_W-1:OP_W-5], upper-aligned
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  rising-edge clock
- reset_n  in  1  one clock; reset is asynchronous and active-low
- op  in  OP_W  opcode from instruction register (valid from DECODE onward)
- mem_ready  in  1  memory completes current read/write this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread / memwrite  out  1  memory request strobes
- irwrite, pcwrite  out  1  IR / PC load enables
- pcwrite_eq / pcwrite_ne  out  1  conditional PC load on zero / not-zero
- alusrca  out  1  0 = PC, 1 = regA
- alusrcb  out  2  00 = regB, 01 = const 1, 10 = sign-ext imm
- aluop  out  2  00 add, 11 subtract, 10 R-type (funct via ALU decoder)
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 trap vector
- regdst, memtoreg, regwrite, link  out  1  write-back controls; link writes PC to r31
- illegal  out  1  one-cycle pulse on an illegal opcode
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- Opcode classes on the top 5 bits:
  - top2 ∈ {01, 10}: R-type
  - 11000: ADDI
  - 11001: SUBI
  - 11010: LW
  - 11011: SW
  - 11100: BEQ
  - 11101: BNE
  - 00000: J
  - 00111: JAL
  - anything else: illegal
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcwrite=mem_ready (Mealy).
  - Leaves to DECODE only when mem_ready=1; holds otherwise.
- DECODE: alusrca=0, alusrcb=10, aluop=00 (branch target precompute). Next state by class:
  - R-type → EXEC
  - ADDI/SUBI → IEXEC
  - LW/SW → MEMADR
  - BEQ/BNE → BRANCH
  - J/JAL → JUMP
  - illegal → TRAP
- EXEC: alusrca=1, alusrcb=00, aluop=10 → ALUWB.
- ALUWB: regdst=1, regwrite=1 → FETCH.
- IEXEC: alusrca=1, alusrcb=10; aluop=00 (ADDI) or 11 (SUBI) → IWB.
- IWB: regdst=0, regwrite=1 → FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=00 → MEMRD (LW) or MEMWR (SW).
- MEMRD: memread=1, iord=1; holds until mem_ready → MEMWB.
- MEMWB: memtoreg=1, regwrite=1 → FETCH.
- MEMWR: memwrite=1, iord=1; holds until mem_ready → FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=11, pcsrc=01, pcwrite_eq (BEQ) or pcwrite_ne (BNE) → FETCH.
- JUMP: pcsrc=10, pcwrite=1; for JAL also link=1, regwrite=1 → FETCH.
- TRAP: illegal=1, pcsrc=11, pcwrite=1 → FETCH; not counted as retired.
- Any output not listed for a state is 0.
- instr_count increments by 1 on every transition into FETCH from ALUWB, IWB, MEMWB, MEMWR, BRANCH or JUMP.

## Timing
- State register and counter are async-cleared by reset_n low: state=FETCH, instr_count=0.
- All outputs are forced to 0 while reset_n is low, including memread. FETCH outputs appear in the first cycle after release.
- Cycle counts with mem_ready constantly 1:
  - R-type, ADDI/SUBI, SW: 4
  - LW: 5
  - BEQ/BNE, J/JAL, illegal: 3
- Each memory stall cycle adds exactly one cycle.
- memread/memwrite and iord stay stable across stall cycles; irwrite/pcwrite never assert in FETCH without mem_ready.
- Reset asserted mid-instruction (including during a stall) abandons it. No counter increment, no write enable after the reset edge.
- op is sampled only in DECODE and IEXEC; changes elsewhere are ignored.
- Counter wrap: from all-ones it goes to 0 with no flag.

## Structure
- Package mc_ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, ALUWB, IEXEC, IWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP, TRAP)
  - opcode constants
  - aluop and pcsrc encodings
- Sub-module mc_op_class: combinational classifier from the top 5 opcode bits to a one-hot class vector plus an illegal flag. The FSM instantiates it.

## Test plan
- R-type op=5'b01010, mem_ready=1 → FETCH, DECODE, EXEC (aluop=10), ALUWB (regdst=1, regwrite=1); instr_count 0→1 on cycle 4.
- LW op=5'b11010, mem_ready low 2 cycles in MEMRD → memread=1 and iord=1 held 3 cycles; MEMWB memtoreg=1; total 7 cycles.
- BNE op=5'b11101 → BRANCH shows aluop=11, pcsrc=01, pcwrite_ne=1, pcwrite_eq=0; JAL op=5'b00111 → JUMP shows link=1, regwrite=1, pcsrc=10.
- Illegal op=5'b11110 → single-cycle illegal=1 with pcsrc=11, pcwrite=1; back in FETCH; instr_count unchanged.
- reset_n dropped during MEMWR stall → all outputs 0 immediately; after release state=FETCH, instr_count=0, no memwrite.
- CNT_W=4, retire 17 SW instructions → instr_count reads 1 after wrap.
